// File: rtl/bsg_mux_one_hot_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_mux_one_hot_rr_arb
//  Purpose  : Round-robin arbiter in front of a shared one-hot AND-OR mux,
//             feeding a single-entry valid/ready output register.
//             Define BSG_MUX_ONE_HOT_RR_ARB_LOCK_EN to hold a grant for the
//             whole of a multi-beat packet (last_i-delimited).
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_mux_one_hot_rr_arb #(
    parameter int width_p = 32,
    parameter int els_p   = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [els_p-1:0]         v_i,
    input  logic [els_p*width_p-1:0] data_i,
    input  logic [els_p-1:0]         last_i,
    output logic [els_p-1:0]         yumi_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic                     last_o,
    output logic [els_p-1:0]         sel_one_hot_o,
    input  logic                     ready_i
);

    localparam int                 c_ptr_w    = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(els_p - 1);

    logic                 r_v;
    logic [width_p-1:0]   r_data;
    logic                 r_last;
    logic [els_p-1:0]     r_sel;
    logic [c_ptr_w-1:0]   r_ptr;

    logic                 w_accept;
    logic [els_p-1:0]     w_req;
    logic [els_p-1:0]     w_grant;
    logic [c_ptr_w-1:0]   w_grant_idx;
    logic [c_ptr_w-1:0]   w_scan_idx;
    logic                 w_found;
    logic [width_p-1:0]   w_mux_data;
    logic                 w_mux_last;
    logic                 w_load;

    assign w_accept = ~r_v | ready_i;

`ifdef BSG_MUX_ONE_HOT_RR_ARB_LOCK_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_ptr_w-1:0] r_lock_idx;

    // While locked, only the owner of the open packet is eligible.
    always_comb begin
        w_req = '0;
        for (int k = 0; k < els_p; k++) begin
            if (r_state == ST_IDLE || c_ptr_w'(k) == r_lock_idx) begin
                w_req[k] = v_i[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state    <= ST_IDLE;
            r_lock_idx <= '0;
        end else if (w_load) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_mux_last) begin
                        r_state    <= ST_LOCKED;
                        r_lock_idx <= w_grant_idx;
                    end
                end
                ST_LOCKED: begin
                    if (w_mux_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`else
    assign w_req = v_i;
`endif

    // Scan upward from the slot after the last winner, wrapping at els_p.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = r_ptr;
        w_found     = 1'b0;
        w_scan_idx  = r_ptr;
        for (int i = 0; i < els_p; i++) begin
            w_scan_idx = (w_scan_idx == c_ptr_last) ? '0 : w_scan_idx + c_ptr_w'(1);
            if (!w_found && w_req[w_scan_idx]) begin
                w_found              = 1'b1;
                w_grant[w_scan_idx]  = 1'b1;
                w_grant_idx          = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_mux_data = '0;
        for (int k = 0; k < els_p; k++) begin
            w_mux_data = w_mux_data | (data_i[k*width_p +: width_p] & {width_p{w_grant[k]}});
        end
    end

    assign w_mux_last = |(last_i & w_grant);
    assign w_load     = w_accept & w_found;
    assign yumi_o     = w_grant & {els_p{w_accept & reset_n_i}};

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_v    <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
            r_sel  <= '0;
            r_ptr  <= c_ptr_last;
        end else if (w_accept) begin
            if (w_found) begin
                r_v    <= 1'b1;
                r_data <= w_mux_data;
                r_last <= w_mux_last;
                r_sel  <= w_grant;
                r_ptr  <= w_grant_idx;
            end else begin
                r_v <= 1'b0;
            end
        end
    end

    assign v_o           = r_v;
    assign data_o        = r_data;
    assign last_o        = r_last;
    assign sel_one_hot_o = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_bsg_mux_one_hot_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_mux_one_hot_rr_arb
//  Purpose  : Directed-vector bench with a beat scoreboard for the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_mux_one_hot_rr_arb;

    localparam int c_w = 32;
    localparam int c_n = 2;

    logic               clk_i = 1'b0;
    logic               reset_n_i;
    logic [c_n-1:0]     v_i;
    logic [c_n*c_w-1:0] data_i;
    logic [c_n-1:0]     last_i;
    logic [c_n-1:0]     yumi_o;
    logic               v_o;
    logic [c_w-1:0]     data_o;
    logic               last_o;
    logic [c_n-1:0]     sel_one_hot_o;
    logic               ready_i;

    bsg_mux_one_hot_rr_arb #(.width_p(c_w), .els_p(c_n)) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .v_i           (v_i),
        .data_i        (data_i),
        .last_i        (last_i),
        .yumi_o        (yumi_o),
        .v_o           (v_o),
        .data_o        (data_o),
        .last_o        (last_o),
        .sel_one_hot_o (sel_one_hot_o),
        .ready_i       (ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst_n;
        logic [1:0]  v;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  last;
        logic        rdy;
        logic [1:0]  yumi;
        logic        vo;
        logic        zchk;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  sel;
    } beat_t;

    vec_t  vecs[$];
    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic add(input logic rst_n, input logic [1:0] v, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [1:0] last, input logic rdy,
                       input logic [1:0] yumi, input logic vo, input logic zchk);
        vec_t t;
        t.rst_n = rst_n; t.v = v; t.d0 = d0; t.d1 = d1; t.last = last;
        t.rdy = rdy; t.yumi = yumi; t.vo = vo; t.zchk = zchk;
        vecs.push_back(t);
    endtask

    task automatic build_vectors();
        // reset held with both requesters valid
        for (int i = 0; i < 3; i++)
            add(0, 2'b11, 32'hAAAA_0000, 32'hBBBB_0001, 2'b11, 1, 2'b00, 0, 1);
        // fairness: grants alternate starting at requester 0
        add(1, 2'b11, 32'hAAAA_0000, 32'hBBBB_0001, 2'b11, 1, 2'b01, 0, 1);
        add(1, 2'b11, 32'hAAAA_0000, 32'hBBBB_0001, 2'b11, 1, 2'b10, 1, 0);
        add(1, 2'b11, 32'hAAAA_0000, 32'hBBBB_0001, 2'b11, 1, 2'b01, 1, 0);
        add(1, 2'b11, 32'hAAAA_0000, 32'hBBBB_0001, 2'b11, 1, 2'b10, 1, 0);
        // backpressure: nothing consumed, held beat stable
        for (int i = 0; i < 4; i++)
            add(1, 2'b11, 32'hDEAD_0000, 32'hDEAD_0001, 2'b11, 0, 2'b00, 1, 0);
        add(1, 2'b10, 32'hEEEE_0000, 32'hCCCC_0002, 2'b11, 1, 2'b10, 1, 0);
        // drain to empty, then pointer still at 1 so requester 0 wins
        add(1, 2'b00, 32'h0, 32'h0, 2'b00, 1, 2'b00, 1, 0);
        add(1, 2'b00, 32'h0, 32'h0, 2'b00, 1, 2'b00, 0, 0);
        add(1, 2'b11, 32'h1111_0000, 32'h2222_0000, 2'b11, 1, 2'b01, 0, 0);
        add(1, 2'b00, 32'h0, 32'h0, 2'b00, 1, 2'b00, 1, 0);
        add(1, 2'b00, 32'h0, 32'h0, 2'b00, 1, 2'b00, 0, 0);
        // reset to restore priority, then a 3-beat packet from requester 0
        add(0, 2'b00, 32'h0, 32'h0, 2'b00, 1, 2'b00, 0, 0);
        add(1, 2'b11, 32'h1000_0001, 32'h2000_0000, 2'b10, 1, 2'b01, 0, 1);
`ifdef BSG_MUX_ONE_HOT_RR_ARB_LOCK_EN
        add(1, 2'b11, 32'h1000_0002, 32'h2000_0000, 2'b10, 1, 2'b01, 1, 0);
`else
        add(1, 2'b11, 32'h1000_0002, 32'h2000_0000, 2'b10, 1, 2'b10, 1, 0);
`endif
        add(1, 2'b11, 32'h1000_0003, 32'h2000_0000, 2'b11, 1, 2'b01, 1, 0);
        add(1, 2'b11, 32'h1000_0004, 32'h2000_0001, 2'b11, 1, 2'b10, 1, 0);
        add(1, 2'b00, 32'h0, 32'h0, 2'b00, 1, 2'b00, 1, 0);
        add(1, 2'b00, 32'h0, 32'h0, 2'b00, 1, 2'b00, 0, 0);
        // open a packet on requester 1, then reset mid-packet
        add(1, 2'b10, 32'h0, 32'h3000_0000, 2'b00, 1, 2'b10, 0, 0);
`ifdef BSG_MUX_ONE_HOT_RR_ARB_LOCK_EN
        add(1, 2'b11, 32'h4000_0000, 32'h3000_0001, 2'b00, 1, 2'b10, 1, 0);
`else
        add(1, 2'b11, 32'h4000_0000, 32'h3000_0001, 2'b00, 1, 2'b01, 1, 0);
`endif
        add(0, 2'b11, 32'h4000_0001, 32'h3000_0002, 2'b00, 1, 2'b00, 1, 0);
        add(1, 2'b11, 32'h5000_0000, 32'h6000_0000, 2'b11, 1, 2'b01, 0, 1);
        add(1, 2'b00, 32'h0, 32'h0, 2'b00, 1, 2'b00, 1, 0);
        add(1, 2'b00, 32'h0, 32'h0, 2'b00, 1, 2'b00, 0, 0);
    endtask

    // Monitor: every cycle with a held beat is checked against the head
    // of the scoreboard; the head is retired when the consumer takes it.
    always @(negedge clk_i) begin
        if (v_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL beat_unexpected: v_o=1 data_o=%h, no beat expected", data_o);
            end else begin
                n_cmp++;
                if (data_o !== sb[0].data) begin
                    n_err++;
                    $display("FAIL beat_data: got %h want %h", data_o, sb[0].data);
                end
                n_cmp++;
                if (last_o !== sb[0].last) begin
                    n_err++;
                    $display("FAIL beat_last: got %b want %b", last_o, sb[0].last);
                end
                n_cmp++;
                if (sel_one_hot_o !== sb[0].sel) begin
                    n_err++;
                    $display("FAIL beat_sel: got %b want %b", sel_one_hot_o, sb[0].sel);
                end
                if (ready_i === 1'b1) void'(sb.pop_front());
            end
        end
    end

    initial begin
        beat_t pend;
        logic  have_pend;
        have_pend = 1'b0;
        build_vectors();
        reset_n_i = 1'b0; v_i = '0; data_i = '0; last_i = '0; ready_i = 1'b1;
        @(posedge clk_i);
        for (int n = 0; n < vecs.size(); n++) begin
            @(posedge clk_i);
            if (have_pend) begin
                sb.push_back(pend);
                have_pend = 1'b0;
            end
            #1;
            reset_n_i = vecs[n].rst_n;
            v_i       = vecs[n].v;
            data_i    = {vecs[n].d1, vecs[n].d0};
            last_i    = vecs[n].last;
            ready_i   = vecs[n].rdy;
            @(negedge clk_i);
            n_cmp++;
            if (yumi_o !== vecs[n].yumi) begin
                n_err++;
                $display("FAIL yumi[%0d]: got %b want %b", n, yumi_o, vecs[n].yumi);
            end
            n_cmp++;
            if (v_o !== vecs[n].vo) begin
                n_err++;
                $display("FAIL v_o[%0d]: got %b want %b", n, v_o, vecs[n].vo);
            end
            if (vecs[n].zchk) begin
                n_cmp++;
                if (data_o !== 32'h0 || last_o !== 1'b0 || sel_one_hot_o !== 2'b00) begin
                    n_err++;
                    $display("FAIL reset_regs[%0d]: got data=%h last=%b sel=%b want 0/0/0",
                             n, data_o, last_o, sel_one_hot_o);
                end
            end
            if (vecs[n].yumi != 2'b00) begin
                pend.data = vecs[n].yumi[0] ? vecs[n].d0 : vecs[n].d1;
                pend.last = vecs[n].yumi[0] ? vecs[n].last[0] : vecs[n].last[1];
                pend.sel  = vecs[n].yumi;
                have_pend = 1'b1;
            end
        end
        @(posedge clk_i);
        if (have_pend) sb.push_back(pend);
        repeat (3) @(posedge clk_i);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d beats left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
